// File: rtl/peak_detect_stream.sv
// peak_detect_stream
//   Collects one batch of BATCH_SIZE complex FFT bins and keeps, per window,
//   the bin with the largest re^2+im^2 that reaches the batch threshold. After
//   the final bin it streams NPEAKS records (sop on record 0, eop on the last)
//   under source_ready backpressure, then returns to accepting input.
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   sink_sop/eop/valid, sink_ready    input framing and handshake
//   sink_re, sink_im                  signed bin value
//   threshold                         minimum mag^2, latched on the sop beat
//   source_sop/eop/valid/ready        output framing and handshake
//   source_bin/mag2/re/im/found       peak record for the current window
//   source_mag2_left/right            neighbour mag^2 (PEAK_DETECT_NEIGHBOUR_EN)
// Optional feature macro: PEAK_DETECT_NEIGHBOUR_EN
module peak_detect_stream #(
  parameter int BATCH_SIZE = 1024,
  parameter int DATA_WIDTH = 20,
  parameter int NPEAKS     = 4,
  parameter int PEAKDEV    = 51,
  localparam int ADDR_WIDTH = $clog2(BATCH_SIZE),
  localparam int MAG_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [DATA_WIDTH-1:0] sink_re,
  input  logic [DATA_WIDTH-1:0] sink_im,
  input  logic [MAG_WIDTH-1:0]  threshold,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [ADDR_WIDTH-1:0] source_bin,
  output logic [MAG_WIDTH-1:0]  source_mag2,
  output logic [DATA_WIDTH-1:0] source_re,
  output logic [DATA_WIDTH-1:0] source_im,
  output logic                  source_found
`ifdef PEAK_DETECT_NEIGHBOUR_EN
  ,
  output logic [MAG_WIDTH-1:0]  source_mag2_left,
  output logic [MAG_WIDTH-1:0]  source_mag2_right
`endif
);

  localparam int IDX_W = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  // Rounded centre of window i: round((i+1)*BATCH_SIZE/(NPEAKS+1)).
  function automatic int centre_f(input int i);
    return ((i + 1) * BATCH_SIZE * 2 + NPEAKS + 1) / (2 * (NPEAKS + 1));
  endfunction

  state_t                  state_q, state_d;
  logic                    sink_ready_q, sink_ready_d;
  logic [ADDR_WIDTH-1:0]   pos_q, pos_d, pos_eff;
  logic [MAG_WIDTH-1:0]    thr_q, thr_d, thr_eff;
  logic [MAG_WIDTH-1:0]    best_q [NPEAKS];
  logic [MAG_WIDTH-1:0]    best_d [NPEAKS];
  logic [ADDR_WIDTH-1:0]   bin_q  [NPEAKS];
  logic [ADDR_WIDTH-1:0]   bin_d  [NPEAKS];
  logic [DATA_WIDTH-1:0]   re_q   [NPEAKS];
  logic [DATA_WIDTH-1:0]   re_d   [NPEAKS];
  logic [DATA_WIDTH-1:0]   im_q   [NPEAKS];
  logic [DATA_WIDTH-1:0]   im_d   [NPEAKS];
  logic [NPEAKS-1:0]       found_q, found_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    src_valid_q, src_valid_d, src_sop_q, src_sop_d;
  logic                    src_eop_q, src_eop_d, src_found_q, src_found_d;
  logic [ADDR_WIDTH-1:0]   src_bin_q, src_bin_d;
  logic [MAG_WIDTH-1:0]    src_mag2_q, src_mag2_d;
  logic [DATA_WIDTH-1:0]   src_re_q, src_re_d, src_im_q, src_im_d;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
  logic [MAG_WIDTH-1:0]    prev_mag2_q, prev_mag2_d;
  logic [MAG_WIDTH-1:0]    left_q  [NPEAKS];
  logic [MAG_WIDTH-1:0]    left_d  [NPEAKS];
  logic [MAG_WIDTH-1:0]    right_q [NPEAKS];
  logic [MAG_WIDTH-1:0]    right_d [NPEAKS];
  logic [NPEAKS-1:0]       pend_q, pend_d;
  logic [MAG_WIDTH-1:0]    src_left_q, src_left_d, src_right_q, src_right_d;
`endif

  logic                    accept, start, beat, load_en;
  logic [IDX_W-1:0]        sel;
  logic [NPEAKS-1:0]       in_win;
  logic [NPEAKS-1:0][ADDR_WIDTH-1:0] centre_bin;
  logic signed [MAG_WIDTH-1:0] re_ext, im_ext, re_sq, im_sq;
  logic [MAG_WIDTH-1:0]    mag2;

  assign accept  = sink_valid && sink_ready_q;
  // A sop beat always (re)starts a batch, from IDLE or mid-LOAD.
  assign start   = accept && sink_sop;
  assign beat    = accept && (sink_sop || (state_q == LOAD));
  assign pos_eff = start ? '0 : pos_q;
  assign thr_eff = start ? threshold : thr_q;

  // Operands are sign-extended to full width so each square is exact and
  // the unsigned sum of two squares cannot overflow MAG_WIDTH bits.
  assign re_ext = $signed({{DATA_WIDTH{sink_re[DATA_WIDTH-1]}}, sink_re});
  assign im_ext = $signed({{DATA_WIDTH{sink_im[DATA_WIDTH-1]}}, sink_im});
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign mag2   = $unsigned(re_sq) + $unsigned(im_sq);

  for (genvar gi = 0; gi < NPEAKS; gi++) begin : g_win
    localparam int C  = centre_f(gi);
    localparam int LO = (C - PEAKDEV < 0) ? 0 : C - PEAKDEV;
    localparam int HI = (C + PEAKDEV - 1 > BATCH_SIZE - 1) ? BATCH_SIZE - 1 : C + PEAKDEV - 1;
    assign in_win[gi]     = (int'(pos_eff) >= LO) && (int'(pos_eff) <= HI);
    assign centre_bin[gi] = ADDR_WIDTH'(C);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (start)
          state_d = sink_eop ? IDLE : LOAD;
        else if (accept && state_q == LOAD) begin
          if (pos_q == ADDR_WIDTH'(BATCH_SIZE - 1)) state_d = EMIT;
          else if (sink_eop)                        state_d = IDLE;
        end
      end
      EMIT: begin
        if (src_valid_q && source_ready && idx_q == IDX_W'(NPEAKS - 1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: sink_ready and the record stream. The first EMIT cycle
  // only loads record 0, which gives the one-cycle gap after the last bin.
  always_comb begin
    sink_ready_d = (state_d != EMIT);
    idx_d        = start ? '0 : idx_q;
    load_en      = 1'b0;
    sel          = idx_q;
    src_valid_d  = src_valid_q;
    src_sop_d    = src_sop_q;
    src_eop_d    = src_eop_q;
    src_bin_d    = src_bin_q;
    src_mag2_d   = src_mag2_q;
    src_re_d     = src_re_q;
    src_im_d     = src_im_q;
    src_found_d  = src_found_q;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
    src_left_d   = src_left_q;
    src_right_d  = src_right_q;
`endif
    if (state_q == EMIT) begin
      if (!src_valid_q) begin
        load_en = 1'b1;
      end else if (source_ready) begin
        if (idx_q == IDX_W'(NPEAKS - 1)) begin
          src_valid_d = 1'b0;
          src_sop_d   = 1'b0;
          src_eop_d   = 1'b0;
          src_bin_d   = '0;
          src_mag2_d  = '0;
          src_re_d    = '0;
          src_im_d    = '0;
          src_found_d = 1'b0;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
          src_left_d  = '0;
          src_right_d = '0;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          sel     = idx_q + 1'b1;
          load_en = 1'b1;
        end
      end
    end
    if (load_en) begin
      src_valid_d = 1'b1;
      src_sop_d   = (sel == '0);
      src_eop_d   = (sel == IDX_W'(NPEAKS - 1));
      src_bin_d   = bin_q[sel];
      src_mag2_d  = best_q[sel];
      src_re_d    = re_q[sel];
      src_im_d    = im_q[sel];
      src_found_d = found_q[sel];
`ifdef PEAK_DETECT_NEIGHBOUR_EN
      src_left_d  = left_q[sel];
      src_right_d = right_q[sel];
`endif
    end
  end

  // Window tracking. Clearing happens before the compare so bin 0 of a new
  // batch is judged against empty windows and the freshly sampled threshold.
  always_comb begin
    pos_d   = pos_q;
    thr_d   = thr_q;
    found_d = found_q;
    for (int i = 0; i < NPEAKS; i++) begin
      best_d[i] = best_q[i];
      bin_d[i]  = bin_q[i];
      re_d[i]   = re_q[i];
      im_d[i]   = im_q[i];
`ifdef PEAK_DETECT_NEIGHBOUR_EN
      left_d[i]  = left_q[i];
      right_d[i] = right_q[i];
`endif
    end
`ifdef PEAK_DETECT_NEIGHBOUR_EN
    pend_d      = pend_q;
    prev_mag2_d = prev_mag2_q;
`endif
    if (start) begin
      thr_d   = threshold;
      found_d = '0;
      for (int i = 0; i < NPEAKS; i++) begin
        best_d[i] = '0;
        bin_d[i]  = centre_bin[i];
        re_d[i]   = '0;
        im_d[i]   = '0;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
        left_d[i]  = '0;
        right_d[i] = '0;
`endif
      end
`ifdef PEAK_DETECT_NEIGHBOUR_EN
      pend_d = '0;
`endif
    end
    if (beat) begin
      pos_d = pos_eff + 1'b1;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
      prev_mag2_d = mag2;
`endif
      for (int i = 0; i < NPEAKS; i++) begin
`ifdef PEAK_DETECT_NEIGHBOUR_EN
        // Right neighbour of the previous peak; a new peak below overrides it.
        if (pend_d[i]) begin
          right_d[i] = mag2;
          pend_d[i]  = 1'b0;
        end
`endif
        if (in_win[i] && (mag2 > best_d[i]) && (mag2 >= thr_eff)) begin
          best_d[i]  = mag2;
          bin_d[i]   = pos_eff;
          re_d[i]    = sink_re;
          im_d[i]    = sink_im;
          found_d[i] = 1'b1;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
          left_d[i]  = (pos_eff == '0) ? '0 : prev_mag2_q;
          right_d[i] = '0;
          pend_d[i]  = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sink_ready_q <= 1'b0;
      pos_q        <= '0;
      thr_q        <= '0;
      found_q      <= '0;
      idx_q        <= '0;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      src_bin_q    <= '0;
      src_mag2_q   <= '0;
      src_re_q     <= '0;
      src_im_q     <= '0;
      src_found_q  <= 1'b0;
      for (int i = 0; i < NPEAKS; i++) begin
        best_q[i] <= '0;
        bin_q[i]  <= centre_bin[i];
        re_q[i]   <= '0;
        im_q[i]   <= '0;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
        left_q[i]  <= '0;
        right_q[i] <= '0;
`endif
      end
`ifdef PEAK_DETECT_NEIGHBOUR_EN
      pend_q      <= '0;
      prev_mag2_q <= '0;
      src_left_q  <= '0;
      src_right_q <= '0;
`endif
    end else begin
      sink_ready_q <= sink_ready_d;
      pos_q        <= pos_d;
      thr_q        <= thr_d;
      found_q      <= found_d;
      idx_q        <= idx_d;
      src_valid_q  <= src_valid_d;
      src_sop_q    <= src_sop_d;
      src_eop_q    <= src_eop_d;
      src_bin_q    <= src_bin_d;
      src_mag2_q   <= src_mag2_d;
      src_re_q     <= src_re_d;
      src_im_q     <= src_im_d;
      src_found_q  <= src_found_d;
      for (int i = 0; i < NPEAKS; i++) begin
        best_q[i] <= best_d[i];
        bin_q[i]  <= bin_d[i];
        re_q[i]   <= re_d[i];
        im_q[i]   <= im_d[i];
`ifdef PEAK_DETECT_NEIGHBOUR_EN
        left_q[i]  <= left_d[i];
        right_q[i] <= right_d[i];
`endif
      end
`ifdef PEAK_DETECT_NEIGHBOUR_EN
      pend_q      <= pend_d;
      prev_mag2_q <= prev_mag2_d;
      src_left_q  <= src_left_d;
      src_right_q <= src_right_d;
`endif
    end
  end

  assign sink_ready   = sink_ready_q;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign source_bin   = src_bin_q;
  assign source_mag2  = src_mag2_q;
  assign source_re    = src_re_q;
  assign source_im    = src_im_q;
  assign source_found = src_found_q;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
  assign source_mag2_left  = src_left_q;
  assign source_mag2_right = src_right_q;
`endif

endmodule

// File: tb/tb_peak_detect_stream.sv
// Directed bench for peak_detect_stream at default parameters.
module tb_peak_detect_stream;
  localparam int B  = 1024;
  localparam int DW = 20;
  localparam int NP = 4;
  localparam int AW = 10;
  localparam int MW = 40;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sink_sop = 1'b0, sink_eop = 1'b0, sink_valid = 1'b0;
  logic          sink_ready;
  logic [DW-1:0] sink_re = '0, sink_im = '0;
  logic [MW-1:0] threshold = '0;
  logic          source_sop, source_eop, source_valid;
  logic          source_ready = 1'b1;
  logic [AW-1:0] source_bin;
  logic [MW-1:0] source_mag2;
  logic [DW-1:0] source_re, source_im;
  logic          source_found;
`ifdef PEAK_DETECT_NEIGHBOUR_EN
  logic [MW-1:0] source_mag2_left, source_mag2_right;
`endif

  peak_detect_stream dut (
    .clk(clk), .reset_n(reset_n),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_valid(sink_valid),
    .sink_ready(sink_ready), .sink_re(sink_re), .sink_im(sink_im),
    .threshold(threshold),
    .source_sop(source_sop), .source_eop(source_eop), .source_valid(source_valid),
    .source_ready(source_ready), .source_bin(source_bin), .source_mag2(source_mag2),
    .source_re(source_re), .source_im(source_im), .source_found(source_found)
`ifdef PEAK_DETECT_NEIGHBOUR_EN
    , .source_mag2_left(source_mag2_left), .source_mag2_right(source_mag2_right)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int            vre [B];
  int            vim [B];
  int            cen [NP] = '{205, 410, 614, 819};
  logic [AW-1:0] exp_bin [NP];
  logic [MW-1:0] exp_mag [NP];
  logic [DW-1:0] exp_re [NP];
  logic [DW-1:0] exp_im [NP];
  logic          exp_found [NP];
  logic [MW-1:0] exp_left [NP];
  logic [MW-1:0] exp_right [NP];

  task automatic clear_all();
    for (int p = 0; p < B; p++) begin vre[p] = 0; vim[p] = 0; end
    for (int k = 0; k < NP; k++) begin
      exp_bin[k] = AW'(cen[k]); exp_mag[k] = '0; exp_re[k] = '0; exp_im[k] = '0;
      exp_found[k] = 1'b0; exp_left[k] = '0; exp_right[k] = '0;
    end
  endtask

  task automatic put(input int p, input int re, input int im);
    vre[p] = re; vim[p] = im;
  endtask

  task automatic expk(input int k, input int bin, input int re, input int im, input int mag);
    exp_bin[k] = AW'(bin); exp_re[k] = DW'(re); exp_im[k] = DW'(im);
    exp_mag[k] = MW'(mag); exp_found[k] = 1'b1;
  endtask

  // Drives n beats back to back; threshold is changed after the sop beat so
  // only the latched value can matter.
  task automatic send_batch(input int n, input int eop_at, input int thr);
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      if (p == 0) check("ready_at_sop", sink_ready, 1);
      threshold  = (p == 0) ? MW'(thr) : '0;
      sink_valid = 1'b1;
      sink_sop   = (p == 0);
      sink_eop   = (p == eop_at);
      sink_re    = DW'(vre[p]);
      sink_im    = DW'(vim[p]);
    end
    @(negedge clk);
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    if (n == B) begin
      check("ready_low_emit", sink_ready, 0);
      check("valid_gap", source_valid, 0);
    end else begin
      check("ready_short", sink_ready, 1);
    end
  endtask

  task automatic get_packet(input int nrec, input int stall_rec, input int stall_cyc);
    int k = 0, t = 0, held = 0;
    while (k < nrec && t < 200) begin
      @(negedge clk);
      t++;
      if (source_valid) begin
        if (k == 0) check("first_latency", t, 1);
        check($sformatf("r%0d_bin", k), source_bin, exp_bin[k]);
        check($sformatf("r%0d_mag2", k), source_mag2, exp_mag[k]);
        check($sformatf("r%0d_re", k), source_re, exp_re[k]);
        check($sformatf("r%0d_im", k), source_im, exp_im[k]);
        check($sformatf("r%0d_found", k), source_found, exp_found[k]);
        check($sformatf("r%0d_sop", k), source_sop, k == 0);
        check($sformatf("r%0d_eop", k), source_eop, k == NP - 1);
`ifdef PEAK_DETECT_NEIGHBOUR_EN
        check($sformatf("r%0d_left", k), source_mag2_left, exp_left[k]);
        check($sformatf("r%0d_right", k), source_mag2_right, exp_right[k]);
`endif
        if (k == stall_rec && held < stall_cyc) begin
          source_ready = 1'b0;
          held++;
          check("ready_low_stall", sink_ready, 0);
        end else begin
          source_ready = 1'b1;
          $display("record %0d: bin=%0d mag2=%0d found=%0d", k, source_bin, source_mag2, source_found);
          k++;
        end
      end
    end
    check("record_count", k, nrec);
  endtask

  task automatic post_idle();
    @(negedge clk);
    check("idle_valid", source_valid, 0);
    check("idle_ready", sink_ready, 1);
  endtask

  task automatic setup_t1();
    clear_all();
    put(200, 3, 4); put(420, -6, 8); put(600, 0, -1); put(830, 100, 0);
    expk(0, 200, 3, 4, 25); expk(1, 420, -6, 8, 100);
    expk(2, 600, 0, -1, 1); expk(3, 830, 100, 0, 10000);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, source_valid, 0);
    check({tag, "_sop"}, source_sop, 0);
    check({tag, "_eop"}, source_eop, 0);
    check({tag, "_bin"}, source_bin, 0);
    check({tag, "_mag2"}, source_mag2, 0);
    check({tag, "_found"}, source_found, 0);
    check({tag, "_re"}, source_re, 0);
    check({tag, "_ready"}, sink_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    #1 check("ready_before_edge", sink_ready, 0);
    @(negedge clk);
    check("ready_after_reset", sink_ready, 1);

    // Four isolated peaks, threshold 0.
    setup_t1();
    send_batch(B, B - 1, 0);
    get_packet(NP, -1, 0);
    post_idle();

    // Equal peaks at 400 and 405: earliest kept; stall on record 1.
    clear_all();
    put(400, 5, 0); put(405, 5, 0);
    expk(1, 400, 5, 0, 25);
    send_batch(B, B - 1, 0);
    get_packet(NP, 1, 5);
    post_idle();

    // Threshold 50: equality accepted, 49 rejected, window edge 869 included,
    // bin 870 outside every window.
    clear_all();
    put(200, 5, 5); put(420, 7, 1); put(600, 7, 0); put(869, -512, -1); put(870, 1000, 0);
    expk(0, 200, 5, 5, 50); expk(1, 420, 7, 1, 50); expk(3, 869, -512, -1, 262145);
    exp_right[3] = MW'(1000000);
    send_batch(B, -1, 50);
    get_packet(NP, -1, 0);
    post_idle();

    // Short batch ending at bin 500 is discarded.
    setup_t1();
    send_batch(501, 500, 0);
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      check("short_no_valid", source_valid, 0);
      check("short_ready", sink_ready, 1);
    end
    send_batch(B, B - 1, 0);
    get_packet(NP, -1, 0);
    post_idle();

    // Reset while record 2 is on the bus.
    setup_t1();
    send_batch(B, B - 1, 0);
    get_packet(2, -1, 0);
    @(negedge clk);
    check("r2_present", source_valid, 1);
    check("r2_bin_before_rst", source_bin, exp_bin[2]);
    reset_n = 1'b0;
    #1 check_outputs_zero("abort");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", sink_ready, 1);
    clear_all();
    put(400, 5, 0); put(405, 5, 0);
    expk(1, 400, 5, 0, 25);
    send_batch(B, B - 1, 0);
    get_packet(NP, -1, 0);
    post_idle();

`ifdef PEAK_DETECT_NEIGHBOUR_EN
    // Peak at 410 with neighbours mag2 8 (left) and 9 (right).
    clear_all();
    put(409, 2, 2); put(410, 10, 0); put(411, 3, 0);
    expk(1, 410, 10, 0, 100);
    exp_left[1] = MW'(8); exp_right[1] = MW'(9);
    send_batch(B, B - 1, 0);
    get_packet(NP, -1, 0);
    post_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
